// File: rtl/rv32_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's MMIO bus.
// A small circular FIFO decouples CPU stores from the serialiser. Stores to
// TXDATA push a byte, and STATUS reports the FIFO and line state. Register
// reads are combinational. The serial line is driven from registered FSM state
// through a small decoder.
module rv32_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_mmio,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        hit,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic          r_ovf;

  logic [1:0]  w_off;
  logic [PW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_baud_end;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic [31:0] w_status;
  logic        w_unused_bits;

  // Region bits are pre-qualified by the decoder; word offset only within the block.
  assign hit   = is_mmio && (mmio_addr[27:4] == BASE_ADDR[27:4]);
  assign w_off = mmio_addr[3:2];

  assign w_unused_bits = ^{mmio_addr[31:28], mmio_addr[1:0], mmio_wdata[31:8]};

  // Pointers carry a wrap bit, so full and empty are distinguished by the count.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == DEPTH_C);
  assign w_empty = (w_count == '0);

  assign w_baud_end = (r_baud == BAUD_LAST);

  // Pop when leaving IDLE or at the last STOP cycle, so frames chain with no gap.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

  // A push into a full FIFO still fits if a pop frees a slot on the same edge.
  assign w_push_req = hit && mmio_we && (w_off == 2'd0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = hit && mmio_we && (w_off == 2'd1) && mmio_wdata[3];

  assign tx_busy = (r_state != S_IDLE) || !w_empty;

  // Assemble the STATUS word from live FIFO and FSM state.
  always_comb begin
    w_status       = '0;
    w_status[0]    = w_full;
    w_status[1]    = w_empty;
    w_status[2]    = (r_state != S_IDLE);
    w_status[3]    = r_ovf;
    w_status[12:8] = 5'(w_count);
  end

  // Zero-latency read mux; only STATUS returns non-zero data.
  always_comb begin
    mmio_rdata = '0;
    if (hit && mmio_re && (w_off == 2'd1)) begin
      mmio_rdata = w_status;
    end
  end

  // Drive the line from state; reset forces IDLE, so the line goes high at once.
  always_comb begin
    case (r_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = r_shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // FIFO storage holds payload only and needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= mmio_wdata[7:0];
    end
  end

  // FIFO pointers and the sticky overflow flag; a set beats a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Load the shift register on a pop and shift right after each data bit.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= r_mem[r_rptr[PW-1:0]];
    end else if ((r_state == S_DATA) && w_baud_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Frame sequencer: each state or bit lasts CLK_DIV cycles, timed by r_baud.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (!w_empty) r_state <= S_START;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= w_empty ? S_IDLE : S_START;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
